lsu_unit: RTL and testbench

Load/store unit between `execute` and the data memory port, replacing the zero-latency `ram` hookup with a handshaked bus that tolerates wait states. It accepts one load or store per instruction from `execute` and drives `stall_o` to freeze `pc_reg` until the access completes. It generates byte enables and store-lane replication, and returns sign- or zero-extended load data to `regs_file`. It also detects misaligned accesses and response timeouts.

---
 rtl/lsu_unit_pkg.sv | 26 ++
 rtl/lsu_unit_align.sv | 60 ++++++
 rtl/lsu_unit.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_unit_pkg;

  // Access size encodings as driven by execute; 2'b11 behaves as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } lsu_state_e;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_unit_align.sv
// Combinational lane logic: store byte enables / replication and
// load lane selection with sign or zero extension.
module lsu_align
  import lsu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [3:0]      st_be_o,
  output logic [XLEN-1:0] st_data_o,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_unsigned_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [XLEN-1:0] ld_data_o
);

  // Store side: replicate the right-aligned data into every lane so the
  // byte enables alone decide which lane memory takes.
  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    case (st_size_i)
      SIZE_BYTE: begin
        st_be_o   = 4'b0001 << st_off_i;
        st_data_o = {(XLEN/8){st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_be_o   = 4'b0011 << {st_off_i[1], 1'b0};
        st_data_o = {(XLEN/16){st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane and extend it to the full width.
  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_size_i)
      SIZE_BYTE: begin
        if (ld_unsigned_i)
          ld_data_o = {{(XLEN-8){1'b0}}, ld_word_i[{ld_off_i, 3'b000} +: 8]};
        else
          ld_data_o = {{(XLEN-8){ld_word_i[{ld_off_i, 3'b111}]}},
                       ld_word_i[{ld_off_i, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        if (ld_unsigned_i)
          ld_data_o = {{(XLEN-16){1'b0}}, ld_word_i[{ld_off_i[1], 4'b0000} +: 16]};
        else
          ld_data_o = {{(XLEN-16){ld_word_i[{ld_off_i[1], 4'b1111}]}},
                       ld_word_i[{ld_off_i[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one access per instruction over a handshaked bus,
// stalling the PC until the access completes, aborts or is rejected.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            stall_o,
  output logic            bus_req_o,
  input  logic            bus_gnt_i,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            wb_en_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o,
  output logic            timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;
  logic            timeout_q, timeout_d;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic            req_misalign;
  logic            idle_ready;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i     (req_size_i),
    .st_off_i      (req_addr_i[1:0]),
    .st_data_i     (req_wdata_i),
    .st_be_o       (st_be),
    .st_data_o     (st_wdata),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_off_i      (off_q),
    .ld_word_i     (bus_rdata_i),
    .ld_data_o     (ld_data)
  );

  assign req_misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
  // The cycle after a load writeback or a timeout, execute still shows the
  // finished instruction (the PC advances at the end of that cycle), so it
  // must not be taken a second time.
  assign idle_ready   = ~(wb_en_q | timeout_q);
  assign req_ready_o  = (state_q == ST_IDLE) & idle_ready;

  // Stall decision: hold the PC while an accepted access is outstanding.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE:   stall_o = req_valid_i & idle_ready & ~req_misalign;
      ST_REQ:    stall_o = ~(bus_gnt_i & bus_we_q);
      ST_WAIT_R: stall_o = 1'b1;
      default:   stall_o = 1'b0;
    endcase
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rd_d        = rd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && idle_ready) begin
          if (req_misalign) begin
            misalign_d = 1'b1;
          end else begin
            size_d      = req_size_i;
            uns_d       = req_unsigned_i;
            off_d       = req_addr_i[1:0];
            rd_d        = req_rd_i;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we_i;
            bus_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = bus_we_q ? ST_IDLE : ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (bus_rvalid_i) begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = ld_data;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign wb_en_o     = wb_en_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: the driver acts as execute and memory and
// pushes expectations; a monitor checks every bus, writeback and error event.
module tb_lsu_unit;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]      req_size_i;
  logic [XLEN-1:0] req_addr_i, req_wdata_i;
  logic [4:0]      req_rd_i;
  logic            stall_o, bus_req_o, bus_gnt_i, bus_we_o;
  logic [XLEN-1:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]      bus_be_o;
  logic            bus_rvalid_i;
  logic            wb_en_o, misalign_o, timeout_o;
  logic [4:0]      wb_addr_o;
  logic [XLEN-1:0] wb_data_o;

  always #5 clk = ~clk;

  lsu_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  int exp_mis = 0;
  int exp_to  = 0;
  int checks  = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event expected=none", name);
  endtask

  // Reference model: access width in bytes from the size code.
  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int off = int'(a[1:0]);
    for (int i = 0; i < nbytes(s); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] w;
    int nb = nbytes(s);
    for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*(j % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rdata);
    int nb = nbytes(s);
    longint v;
    v = longint'(rdata >> (8 * int'(a[1:0]))) & ((longint'(1) << (8*nb)) - 1);
    if (!uns && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
    return v[31:0];
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ctrl"}, {bus_req_o, bus_we_o, wb_en_o, misalign_o, timeout_o, stall_o, bus_be_o, wb_addr_o}, 64'd0);
    chk({tag, "_bus"}, {bus_addr_o, bus_wdata_o}, 64'd0);
    chk({tag, "_wbdata"}, wb_data_o, 64'd0);
    chk({tag, "_ready"}, req_ready_o, 64'd1);
  endtask

  // Execute + memory model for one instruction; returns when stall_o drops.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gw, input int rv,
                        input bit drop, input bit stray);
    int nb, cyc, gcnt, rcnt, exp_lat;
    bit granted, retired, misal;
    bus_exp_t be_e;
    wb_exp_t  wb_e;
    nb    = nbytes(size);
    misal = (int'(addr[1:0]) % nb) != 0;
    if (misal) begin
      exp_mis++;
      exp_lat = 0;
    end else begin
      be_e.we    = we;
      be_e.addr  = {addr[31:2], 2'b00};
      be_e.be    = ref_be(size, addr);
      be_e.wdata = ref_wdata(size, wdata);
      bus_q.push_back(be_e);
      if (we) exp_lat = 1 + gw;
      else if (drop) begin
        exp_to++;
        exp_lat = 2 + gw + TO;
      end else begin
        wb_e.rd   = rd;
        wb_e.data = ref_load(size, uns, addr, rdata);
        wb_q.push_back(wb_e);
        exp_lat = 3 + gw + rv;
      end
    end
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    cyc = 0; gcnt = 0; rcnt = 0; granted = 0; retired = 0;
    while (!retired && cyc < 40) begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      if (granted && !we && !drop) begin
        if (rcnt == rv) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rdata;
        end
        rcnt++;
      end else if (bus_req_o && !granted) begin
        if (gcnt == gw) begin
          bus_gnt_i = 1'b1;
          granted   = 1;
        end else if (stray && ($urandom_range(1) == 1)) begin
          bus_rvalid_i = 1'b1;
        end
        gcnt++;
      end
      if (cyc == 0) chk("req_ready_at_issue", req_ready_o, 64'd1);
      #1;
      if (!stall_o) retired = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!retired) unexpected("stall_never_released");
    else chk("stall_latency", cyc, exp_lat);
    $display("op we=%0b size=%0d uns=%0b addr=%h gw=%0d rv=%0d drop=%0b latency=%0d",
             we, size, uns, addr, gw, rv, drop, cyc);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_i !== 1'b0) continue;
      if (bus_req_o) begin
        if (bus_q.size() == 0) unexpected("bus_req_unexpected");
        else begin
          chk("bus_ctrl", {bus_we_o, bus_be_o, bus_addr_o}, {bus_q[0].we, bus_q[0].be, bus_q[0].addr});
          if (bus_q[0].we) chk("bus_wdata", bus_wdata_o, bus_q[0].wdata);
          if (bus_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (wb_en_o) begin
        if (wb_q.size() == 0) unexpected("wb_unexpected");
        else begin
          chk("wb", {wb_addr_o, wb_data_o}, {wb_q[0].rd, wb_q[0].data});
          void'(wb_q.pop_front());
        end
      end
      if (misalign_o) begin
        if (exp_mis == 0) unexpected("misalign_unexpected");
        else begin checks++; exp_mis--; end
      end
      if (timeout_o) begin
        if (exp_to == 0) unexpected("timeout_unexpected");
        else begin checks++; exp_to--; end
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic        w, dr;
    req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_zero_outputs("reset");

    // Directed cases
    run_op(1, 2'd0, 0, 32'h1003, 32'h0000_00A5, 5'd0, 32'h0, 0, 0, 0, 0);
    run_op(0, 2'd0, 0, 32'h2001, 32'h0, 5'd3, 32'h0000_8000, 0, 0, 0, 0);
    run_op(0, 2'd0, 1, 32'h2001, 32'h0, 5'd4, 32'h0000_8000, 0, 0, 0, 0);
    run_op(0, 2'd1, 0, 32'h2002, 32'h0, 5'd5, 32'h1234_5678, 3, 0, 0, 0);
    run_op(0, 2'd2, 0, 32'h3002, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
    run_op(0, 2'd2, 0, 32'h4000, 32'h0, 5'd7, 32'h0, 0, 0, 1, 0);
    @(negedge clk);
    req_valid_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    idle_cycles(2);

    // Reset while waiting for read data
    bus_q.push_back('{we: 1'b0, addr: 32'h6000, be: 4'b1111, wdata: 32'h0});
    @(negedge clk);
    req_valid_i = 1; req_we_i = 0; req_size_i = 2'd2; req_addr_i = 32'h6000; req_rd_i = 5'd9;
    @(negedge clk);
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; req_valid_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    #1;
    check_zero_outputs("midreset");
    idle_cycles(2);
    run_op(0, 2'd2, 0, 32'h5000, 32'h0, 5'd10, 32'hCAFE_F00D, 1, 2, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 48; n++) begin
      sz = 2'($urandom_range(3));
      a  = $urandom;
      if ($urandom_range(3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
      w  = 1'($urandom_range(1));
      dr = !w && ($urandom_range(7) == 0);
      run_op(w, sz, 1'($urandom_range(1)), a, $urandom, 5'($urandom_range(31)), $urandom,
             $urandom_range(3), $urandom_range(TO - 1), dr, 1);
      if (dr) begin
        @(negedge clk);
        req_valid_i = 1'b0; bus_rvalid_i = 1'b1;
      end
      idle_cycles($urandom_range(2));
    end

    idle_cycles(4);
    chk("bus_queue_drained", bus_q.size(), 64'd0);
    chk("wb_queue_drained", wb_q.size(), 64'd0);
    chk("misalign_pulses_seen", exp_mis, 64'd0);
    chk("timeout_pulses_seen", exp_to, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
